// File: rtl/path_setup_ctrl_pkg.sv
// rtl/path_setup_ctrl_pkg.sv - shared types and constants for the crossbar path-setup controller
package path_setup_ctrl_pkg;

    localparam int PORTS_DEF      = 3;
    localparam int RETRY_WAIT_DEF = 4;
    localparam int MAX_RETRY_DEF  = 3;
    localparam int HOLD_MAX_DEF   = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        CONN    = 2'd2,
        BACKOFF = 2'd3
    } chan_state_t;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } issue_state_t;

    // Bits needed to hold any value in 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/path_chan_fsm.sv
// rtl/path_chan_fsm.sv - per-input channel FSM (IDLE/PEND/CONN/BACKOFF), watchdog under PATH_WATCHDOG_EN
module path_chan_fsm
    import path_setup_ctrl_pkg::*;
#(
    parameter int PORTS      = PORTS_DEF,
    parameter int RETRY_WAIT = RETRY_WAIT_DEF,
    parameter int MAX_RETRY  = MAX_RETRY_DEF,
    parameter int HOLD_MAX   = HOLD_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [PORTS-1:0] req_dest,
    input  logic             req_release,
    input  logic             issue,
    input  logic             grant,
    input  logic             deny,
    output chan_state_t      state,
    output logic [PORTS-1:0] dest,
    output logic             ack,
    output logic             nack,
    output logic [PORTS-1:0] cancel,
    output logic [PORTS-1:0] fail
);

    localparam int RC_W = cnt_width(MAX_RETRY);
    localparam int RW_W = cnt_width(RETRY_WAIT);

    if (RETRY_WAIT < 1 || MAX_RETRY < 1 || HOLD_MAX < 1) begin : g_bad_params
        $error("path_chan_fsm: RETRY_WAIT, MAX_RETRY and HOLD_MAX must all be >= 1");
    end

    logic [RC_W-1:0] retry;
    logic [RW_W-1:0] bo_cnt;

`ifdef PATH_WATCHDOG_EN
    localparam int HOLD_W = cnt_width(HOLD_MAX);
    logic [HOLD_W-1:0] hold;
`else
    assign fail = '0;
`endif

    // Channel state machine; ack/nack/cancel/fail are single-cycle registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            dest   <= '0;
            retry  <= '0;
            bo_cnt <= '0;
            ack    <= 1'b0;
            nack   <= 1'b0;
            cancel <= '0;
`ifdef PATH_WATCHDOG_EN
            fail   <= '0;
            hold   <= '0;
`endif
        end else begin
            ack    <= 1'b0;
            nack   <= 1'b0;
            cancel <= '0;
`ifdef PATH_WATCHDOG_EN
            fail   <= '0;
`endif
            case (state)
                IDLE: begin
                    // The nack cycle is skipped so a requester still holding
                    // valid while it sees the nack does not re-enter PEND.
                    if (req_valid && !nack) begin
                        state <= PEND;
                        dest  <= req_dest;
                        retry <= '0;
                    end
                end
                PEND: begin
                    if (issue && grant) begin
                        state <= CONN;
                        ack   <= 1'b1;
`ifdef PATH_WATCHDOG_EN
                        hold  <= '0;
`endif
                    end else if (issue && (deny || !grant)) begin
                        // A silent arbiter is treated the same as an explicit deny.
                        if (retry == RC_W'(MAX_RETRY - 1)) begin
                            state <= IDLE;
                            nack  <= 1'b1;
                            retry <= '0;
                        end else begin
                            state  <= BACKOFF;
                            retry  <= retry + 1'b1;
                            bo_cnt <= RW_W'(RETRY_WAIT);
                        end
                    end else if (!req_valid) begin
                        state <= IDLE;
                    end
                end
                BACKOFF: begin
                    if (!req_valid) begin
                        state <= IDLE;
                    end else if (bo_cnt <= RW_W'(1)) begin
                        state <= PEND;
                    end else begin
                        bo_cnt <= bo_cnt - 1'b1;
                    end
                end
                CONN: begin
                    // A release in the ack cycle is ignored; release beats timeout.
                    if (req_release && !ack) begin
                        state  <= IDLE;
                        cancel <= dest;
                    end
`ifdef PATH_WATCHDOG_EN
                    else if (hold == HOLD_W'(HOLD_MAX - 1)) begin
                        state <= IDLE;
                        fail  <= dest;
                        nack  <= 1'b1;
                    end else begin
                        hold <= hold + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/path_setup_ctrl.sv
// rtl/path_setup_ctrl.sv - round-robin path-setup front end for the crossbar arbiter (watchdog: PATH_WATCHDOG_EN)
module path_setup_ctrl
    import path_setup_ctrl_pkg::*;
#(
    parameter int PORTS      = PORTS_DEF,
    parameter int RETRY_WAIT = RETRY_WAIT_DEF,
    parameter int MAX_RETRY  = MAX_RETRY_DEF,
    parameter int HOLD_MAX   = HOLD_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PORTS-1:0]       req_valid_i,
    input  logic [PORTS*PORTS-1:0] req_dest_i,
    input  logic [PORTS-1:0]       req_release_i,
    output logic [PORTS-1:0]       req_ack_o,
    output logic [PORTS-1:0]       req_nack_o,
    output logic [PORTS-1:0]       conn_active_o,
    output logic [PORTS-1:0]       arb_stb_o,
    output logic [PORTS-1:0]       arb_src_o,
    output logic [PORTS-1:0]       arb_dest_o,
    output logic [PORTS-1:0]       arb_fail_o,
    output logic [PORTS-1:0]       arb_cancel_o,
    input  logic [PORTS-1:0]       arb_grant_i,
    input  logic [PORTS-1:0]       arb_deny_i
);

    localparam int IDX_W = cnt_width(PORTS - 1);

    chan_state_t      chan_state [PORTS];
    logic [PORTS-1:0] chan_dest  [PORTS];
    logic [PORTS-1:0] cancel_arr [PORTS];
    logic [PORTS-1:0] fail_arr   [PORTS];
    logic [PORTS-1:0] pend;

    issue_state_t     issue_state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic [PORTS-1:0] src_next;

    for (genvar p = 0; p < PORTS; p++) begin : g_chan
        path_chan_fsm #(
            .PORTS      (PORTS),
            .RETRY_WAIT (RETRY_WAIT),
            .MAX_RETRY  (MAX_RETRY),
            .HOLD_MAX   (HOLD_MAX)
        ) u_chan (
            .clk         (clk),
            .rst_n       (reset),
            .req_valid   (req_valid_i[p]),
            .req_dest    (req_dest_i[p*PORTS +: PORTS]),
            .req_release (req_release_i[p]),
            .issue       (arb_src_o[p]),
            .grant       (arb_grant_i[p]),
            .deny        (arb_deny_i[p]),
            .state       (chan_state[p]),
            .dest        (chan_dest[p]),
            .ack         (req_ack_o[p]),
            .nack        (req_nack_o[p]),
            .cancel      (cancel_arr[p]),
            .fail        (fail_arr[p])
        );
        assign pend[p]          = (chan_state[p] == PEND);
        assign conn_active_o[p] = (chan_state[p] == CONN);
    end

    // The strobe covers the presentation cycle and the whole connection.
    assign arb_stb_o = arb_src_o | conn_active_o;

    // Cancels and fails from all channels share the per-output lines, so OR them.
    always_comb begin
        arb_cancel_o = '0;
        arb_fail_o   = '0;
        for (int p = 0; p < PORTS; p++) begin
            arb_cancel_o = arb_cancel_o | cancel_arr[p];
            arb_fail_o   = arb_fail_o | fail_arr[p];
        end
    end

    // Round-robin picker: first pending channel at or after the pointer, wrapping.
    always_comb begin
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        src_next   = '0;
        for (int i = 0; i < PORTS; i++) begin
            cand = int'(ptr) + i;
            if (cand >= PORTS) begin
                cand = cand - PORTS;
            end
            if (!pick_found && pend[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
        src_next[pick_idx] = pick_found;
    end

    // Issue FSM: SCAN -> ISSUE (one cycle on the bus) -> GAP (source forced to zero).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_state <= SCAN;
            ptr         <= '0;
            sel         <= '0;
            arb_src_o   <= '0;
            arb_dest_o  <= '0;
        end else begin
            case (issue_state)
                SCAN: begin
                    if (pick_found) begin
                        issue_state <= ISSUE;
                        sel         <= pick_idx;
                        arb_src_o   <= src_next;
                        arb_dest_o  <= chan_dest[pick_idx];
                    end
                end
                ISSUE: begin
                    issue_state <= GAP;
                    ptr         <= (sel == IDX_W'(PORTS - 1)) ? '0 : sel + 1'b1;
                    arb_src_o   <= '0;
                    arb_dest_o  <= '0;
                end
                GAP:     issue_state <= SCAN;
                default: issue_state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_path_setup_ctrl.sv
// tb/tb_path_setup_ctrl.sv - directed self-checking bench for path_setup_ctrl
module tb_path_setup_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req_valid_i;
    logic [8:0] req_dest_i;
    logic [2:0] req_release_i;
    logic [2:0] req_ack_o;
    logic [2:0] req_nack_o;
    logic [2:0] conn_active_o;
    logic [2:0] arb_stb_o;
    logic [2:0] arb_src_o;
    logic [2:0] arb_dest_o;
    logic [2:0] arb_fail_o;
    logic [2:0] arb_cancel_o;
    logic [2:0] arb_grant_i;
    logic [2:0] arb_deny_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    path_setup_ctrl #(
        .PORTS      (3),
        .RETRY_WAIT (4),
        .MAX_RETRY  (3),
        .HOLD_MAX   (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_i   (req_valid_i),
        .req_dest_i    (req_dest_i),
        .req_release_i (req_release_i),
        .req_ack_o     (req_ack_o),
        .req_nack_o    (req_nack_o),
        .conn_active_o (conn_active_o),
        .arb_stb_o     (arb_stb_o),
        .arb_src_o     (arb_src_o),
        .arb_dest_o    (arb_dest_o),
        .arb_fail_o    (arb_fail_o),
        .arb_cancel_o  (arb_cancel_o),
        .arb_grant_i   (arb_grant_i),
        .arb_deny_i    (arb_deny_i)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b0;
        req_valid_i   = '0;
        req_dest_i    = '0;
        req_release_i = '0;
        arb_grant_i   = '0;
        arb_deny_i    = '0;
        tick;
        tick;
        chk("rst_ack",    req_ack_o,     3'b000);
        chk("rst_nack",   req_nack_o,    3'b000);
        chk("rst_conn",   conn_active_o, 3'b000);
        chk("rst_stb",    arb_stb_o,     3'b000);
        chk("rst_src",    arb_src_o,     3'b000);
        chk("rst_dest",   arb_dest_o,    3'b000);
        chk("rst_fail",   arb_fail_o,    3'b000);
        chk("rst_cancel", arb_cancel_o,  3'b000);
        reset = 1'b1;
        tick;

        // Single request, input 0 -> output 1, granted then released.
        req_valid_i = 3'b001;
        req_dest_i  = 9'b000_000_010;
        tick;
        chk("b_scan_src", arb_src_o, 3'b000);
        tick;
        chk("b_iss_src",  arb_src_o,  3'b001);
        chk("b_iss_dest", arb_dest_o, 3'b010);
        chk("b_iss_stb",  arb_stb_o,  3'b001);
        chk("b_iss_ack",  req_ack_o,  3'b000);
        arb_grant_i = 3'b001;
        tick;
        chk("b_ack",     req_ack_o,     3'b001);
        chk("b_conn",    conn_active_o, 3'b001);
        chk("b_gap_src", arb_src_o,     3'b000);
        chk("b_stb",     arb_stb_o,     3'b001);
        arb_grant_i = '0;
        req_valid_i = '0;
        tick;
        chk("b_ack_clr",   req_ack_o,     3'b000);
        chk("b_conn_hold", conn_active_o, 3'b001);
        req_release_i = 3'b001;
        tick;
        chk("b_cancel",    arb_cancel_o,  3'b010);
        chk("b_stb_drop",  arb_stb_o,     3'b000);
        chk("b_conn_drop", conn_active_o, 3'b000);
        req_release_i = '0;
        tick;
        chk("b_cancel_clr", arb_cancel_o, 3'b000);

        // Input 1 -> output 2: deny, silent arbiter, deny -> nack on third attempt.
        req_valid_i = 3'b010;
        req_dest_i  = 9'b000_100_000;
        tick;
        tick;
        for (int a = 0; a < 3; a++) begin
            chk("c_iss_src",  arb_src_o,  3'b010);
            chk("c_iss_dest", arb_dest_o, 3'b100);
            arb_deny_i = (a == 1) ? 3'b000 : 3'b010;
            tick;
            arb_deny_i = '0;
            if (a < 2) begin
                chk("c_no_nack", req_nack_o, 3'b000);
                chk("c_bo_stb",  arb_stb_o,  3'b000);
                for (int k = 0; k < 5; k++) begin
                    chk("c_bo_src", arb_src_o, 3'b000);
                    tick;
                end
            end else begin
                chk("c_nack", req_nack_o,    3'b010);
                chk("c_conn", conn_active_o, 3'b000);
                req_valid_i = '0;
                tick;
                chk("c_nack_clr", req_nack_o, 3'b000);
                for (int k = 0; k < 4; k++) begin
                    chk("c_idle_src", arb_src_o, 3'b000);
                    tick;
                end
            end
        end

        // Fresh reset so the round-robin pointer restarts at 0.
        reset = 1'b0;
        tick;
        reset = 1'b1;
        tick;

        // All three inputs request together.
        req_valid_i = 3'b111;
        req_dest_i  = 9'b100_010_001;
        tick;
        tick;
        chk("d_iss0_src",  arb_src_o,  3'b001);
        chk("d_iss0_dest", arb_dest_o, 3'b001);
        arb_grant_i = 3'b001;
        tick;
        chk("d_ack0",    req_ack_o, 3'b001);
        chk("d_gap_src", arb_src_o, 3'b000);
        arb_grant_i   = '0;
        req_valid_i   = 3'b110;
        req_release_i = 3'b001;
        tick;
        chk("d_rel_ack_conn",   conn_active_o, 3'b001);
        chk("d_rel_ack_cancel", arb_cancel_o,  3'b000);
        chk("d_scan_src",       arb_src_o,     3'b000);
        req_release_i = '0;
        tick;
        chk("d_iss1_src",  arb_src_o,  3'b010);
        chk("d_iss1_dest", arb_dest_o, 3'b010);
        arb_grant_i = 3'b010;
        tick;
        chk("d_ack1",  req_ack_o,     3'b010);
        chk("d_conn1", conn_active_o, 3'b011);
        arb_grant_i = '0;
        req_valid_i = 3'b100;
        tick;
        chk("d_scan2_src", arb_src_o, 3'b000);
        tick;
        chk("d_iss2_src",  arb_src_o,  3'b100);
        chk("d_iss2_dest", arb_dest_o, 3'b100);
        arb_grant_i = 3'b100;
        tick;
        chk("d_ack2",  req_ack_o,     3'b100);
        chk("d_conn2", conn_active_o, 3'b111);
        chk("d_stb2",  arb_stb_o,     3'b111);
        arb_grant_i = '0;
        req_valid_i = '0;
        tick;
        req_release_i = 3'b100;
        tick;
        chk("d_cancel2", arb_cancel_o,  3'b100);
        chk("d_stb_rel", arb_stb_o,     3'b011);
        chk("d_conn_rel", conn_active_o, 3'b011);
        req_release_i = '0;
        tick;
        chk("d_cancel_clr", arb_cancel_o, 3'b000);

        // Asynchronous reset with two live connections: no cancel.
        reset = 1'b0;
        #1;
        chk("r_stb",    arb_stb_o,     3'b000);
        chk("r_conn",   conn_active_o, 3'b000);
        chk("r_cancel", arb_cancel_o,  3'b000);
        chk("r_ack",    req_ack_o,     3'b000);
        tick;
        chk("r_cancel_hold", arb_cancel_o, 3'b000);
        reset = 1'b1;
        tick;

        // Operation resumes after reset: input 1 -> output 0.
        req_valid_i = 3'b010;
        req_dest_i  = 9'b000_001_000;
        tick;
        tick;
        chk("e_iss_src",  arb_src_o,  3'b010);
        chk("e_iss_dest", arb_dest_o, 3'b001);
        arb_grant_i = 3'b010;
        tick;
        chk("e_ack",  req_ack_o,     3'b010);
        chk("e_conn", conn_active_o, 3'b010);
        arb_grant_i = '0;
        req_valid_i = '0;

`ifdef PATH_WATCHDOG_EN
        for (int k = 0; k < 7; k++) begin
            tick;
            chk("w_conn",    conn_active_o, 3'b010);
            chk("w_no_fail", arb_fail_o,    3'b000);
        end
        tick;
        chk("w_fail",      arb_fail_o,    3'b001);
        chk("w_nack",      req_nack_o,    3'b010);
        chk("w_conn_drop", conn_active_o, 3'b000);
        chk("w_stb_drop",  arb_stb_o,     3'b000);
        tick;
        chk("w_fail_clr", arb_fail_o, 3'b000);
        req_valid_i = 3'b010;
        req_dest_i  = 9'b000_001_000;
        tick;
        tick;
        chk("w2_iss_src", arb_src_o, 3'b010);
        arb_grant_i = 3'b010;
        tick;
        chk("w2_ack", req_ack_o, 3'b010);
        arb_grant_i = '0;
        req_valid_i = '0;
        for (int k = 0; k < 7; k++) begin
            tick;
        end
        req_release_i = 3'b010;
        tick;
        chk("w2_cancel", arb_cancel_o, 3'b001);
        chk("w2_fail",   arb_fail_o,   3'b000);
        chk("w2_nack",   req_nack_o,   3'b000);
        req_release_i = '0;
`else
        tick;
        req_release_i = 3'b010;
        tick;
        chk("e_cancel", arb_cancel_o,  3'b001);
        chk("e_fail",   arb_fail_o,    3'b000);
        chk("e_conn0",  conn_active_o, 3'b000);
        req_release_i = '0;
`endif
        tick;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/path_setup_ctrl.md
Name: path_setup_ctrl

Overview:
- Front-end controller for the crossbar arbiter.
- Collects per-input-port path requests (one-hot destination) and presents them to the arbiter one at a time, in round-robin order.
- Handles grant and deny, and retries with backoff.
- Keeps the per-input strobe asserted while a connection is alive, and pulses the per-output cancel on release.
- Sits between the input-channel buffers and the arbiter.

Parameters:
- PORTS, 3, number of input ports and number of output ports.
- RETRY_WAIT, 4, backoff cycles after a deny before a request is re-presented (>=1).
- MAX_RETRY, 3, denies tolerated before the request is dropped with a nack.
- HOLD_MAX, 64, watchdog limit in cycles for a live connection (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid_i  in  PORTS  input p requests a path; held until ack or nack.
- req_dest_i  in  PORTS*PORTS  slice [p*PORTS+:PORTS] is the one-hot output requested by input p.
- req_release_i  in  PORTS  one-cycle pulse: input p tears down its connection.
- req_ack_o  out  PORTS  one-cycle pulse: path granted.
- req_nack_o  out  PORTS  one-cycle pulse: request dropped after MAX_RETRY denies.
- conn_active_o  out  PORTS  input p holds a connection.
- arb_stb_o  out  PORTS  per-input strobe to the arbiter.
- arb_src_o  out  PORTS  one-hot (or zero) input under arbitration.
- arb_dest_o  out  PORTS  destination of the presented request.
- arb_fail_o  out  PORTS  per-output fail (watchdog only).
- arb_cancel_o  out  PORTS  per-output cancel pulse.
- arb_grant_i  in  PORTS  arbiter grant; same cycle as the presentation.
- arb_deny_i  in  PORTS  arbiter deny; same cycle as the presentation.

Behaviour:
- Reset: all outputs 0; every input channel goes to IDLE; the round-robin pointer is 0; the issue FSM goes to SCAN. Reset asserted mid-operation drops every connection immediately, with no cancel pulse.
- Per-input channel FSM, states IDLE / PEND / CONN / BACKOFF:
  - IDLE to PEND when req_valid_i[p] is high. The destination is latched at this point.
  - PEND: the channel is waiting to be issued.
  - On grant: CONN, with req_ack_o[p] pulsed for 1 cycle.
  - On deny: the retry count increments. If it reaches MAX_RETRY, the channel pulses req_nack_o[p] and goes to IDLE. Otherwise it goes to BACKOFF with the counter loaded to RETRY_WAIT.
  - BACKOFF: counts down to 0, then returns to PEND.
  - CONN to IDLE on req_release_i[p]. In that cycle arb_cancel_o is pulsed at the latched destination bit and arb_stb_o[p] is dropped.
- arb_stb_o[p] is high in the ISSUE cycle for p and throughout CONN; it is low otherwise.
- Issue FSM, states SCAN / ISSUE / GAP:
  - SCAN: picks the first PEND channel starting at the pointer, with wrap-around, then goes to ISSUE. It stays in SCAN if no channel is pending.
  - ISSUE, exactly 1 cycle: arb_src_o = one-hot(p) and arb_dest_o = latched destination. arb_grant_i / arb_deny_i are sampled in this same cycle. The pointer moves to p+1 mod PORTS.
  - GAP, exactly 1 cycle: arb_src_o = 0, so the arbiter sees a source change on the next issue even if the same port is picked again. Then back to SCAN.
  - Minimum spacing between presentations is 3 cycles.
- Neither grant nor deny in the ISSUE cycle counts as a deny.
- A release arriving while the channel is not in CONN is ignored. A release on the ack cycle is ignored.
- When cancels for several ports occur in the same cycle, their bits are ORed.
- If req_valid_i drops while the channel is PEND or BACKOFF, the request is abandoned: the channel returns to IDLE with no ack or nack.
- arb_fail_o is constant 0 unless the optional feature is compiled in.

Optional Feature:
- Macro: PATH_WATCHDOG_EN.
- Defined: each CONN channel runs a hold counter.
  - When the counter reaches HOLD_MAX, arb_fail_o is pulsed for 1 cycle at the held output and arb_stb_o[p] drops.
  - The channel goes to IDLE with a req_nack_o[p] pulse.
  - A release in the same cycle as the timeout takes priority: cancel is pulsed, there is no fail, no nack.
- Undefined: no counters exist and arb_fail_o is tied to 0.

Decomposition:
- Shared package:
  - Channel state encodings: IDLE=2'd0, PEND=2'd1, CONN=2'd2, BACKOFF=2'd3.
  - Issue state encodings: SCAN, ISSUE, GAP.
  - Width constants derived from PORTS, RETRY_WAIT, MAX_RETRY, HOLD_MAX.
- One sub-module: path_chan_fsm, instantiated PORTS times. It holds the channel state, latched destination, retry counter, backoff counter and optional watchdog.
- Top level contains the round-robin picker and the issue FSM.

Test Plan:
- Input 0 requests dest 3'b010; arbiter grants -> ISSUE shows arb_src_o=3'b001, arb_dest_o=3'b010; req_ack_o[0] pulses; arb_stb_o[0] stays 1; conn_active_o=3'b001.
- Inputs 0, 1 and 2 request simultaneously with pointer 0 -> issue order 0, 1, 2; presentations spaced 3 cycles apart; arb_src_o is 0 in every GAP.
- Input 1 is denied 3 times with RETRY_WAIT=4 -> re-presented 4 cycles after each deny (after BACKOFF expires); req_nack_o[1] pulses on the third deny; the channel returns to IDLE.
- Input 2 connected to dest 3'b100 receives req_release_i[2] -> arb_cancel_o=3'b100 for 1 cycle; arb_stb_o[2]=0 in the same cycle; conn_active_o[2]=0.
- reset driven low while 2 connections are active -> all outputs 0 asynchronously; no cancel pulse; after reset is released, requests proceed normally.
- PATH_WATCHDOG_EN with HOLD_MAX=8: connection held without release -> 1-cycle arb_fail_o pulse at the held output and req_nack_o pulse, both after exactly 8 cycles in CONN; release in the timeout cycle -> cancel only.
